imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory. It accepts a framed byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit words. It writes each word, one per cycle, into the word-addressed instruction memory that the fetch stage reads asynchronously by PC. It holds the core in reset until a frame loads with a correct checksum.

## Interface
Parameters:
- WIDTH, 32, instruction word width in bits; also the width of waddr.
- DEPTH, 64, number of instruction words in memory.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- byte_valid  input  1  a byte is offered on byte_data.
- byte_data  input  8  offered byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- we  output  1  memory write strobe, one cycle per word.
- waddr  output  WIDTH  word index being written, 0..DEPTH-1, zero-extended.
- wdata  output  WIDTH  assembled instruction word.
- busy  output  1  a load is in progress (HDR, DATA or CHK).
- done  output  1  last load completed with a good checksum; sticky.
- error  output  1  last load was rejected; sticky.
- cpu_hold  output  1  holds the core in reset; low only in DONE.

## Operation
- Frame format: header byte N (word count), then 4·N payload bytes (little-endian per word, word 0 first), then one checksum byte equal to the XOR of all payload bytes. The header is excluded from the checksum.
- Handshake: a byte transfers on a rising edge with byte_valid=1 and byte_ready=1. byte_ready is combinational from state: 1 in HDR, DATA and CHK, otherwise 0. byte_data is ignored when no transfer occurs. byte_valid may drop between bytes with no effect on state.
- States:
  - IDLE: start → HDR.
  - HDR: accept N. N=0 or N>DEPTH → ERR. Otherwise latch N, clear word_idx, byte_idx and the XOR accumulator → DATA.
  - DATA: each accepted byte is XORed into the accumulator and placed in lane byte_idx (byte_idx 0 → bits 7:0). byte_idx wraps 3→0. On the lane-3 byte, the word is written and word_idx increments. When word_idx reaches N-1 on that byte → CHK.
  - CHK: accept one byte. It equals the accumulator → DONE, otherwise → ERR.
  - DONE: done=1, cpu_hold=0. start → HDR.
  - ERR: error=1, cpu_hold=1. start → HDR.
- Entering HDR from DONE or ERR clears done and error. start in HDR, DATA or CHK is ignored.
- Words already written before an ERR stay in memory. No rollback.
- Reset, including mid-frame: state to IDLE, counters and accumulator cleared. A partial frame is abandoned, and previously written words are untouched.

## Timing
- Reset values: byte_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, error=0, cpu_hold=1.
- we, waddr and wdata are registered. we is high for exactly the one cycle after the lane-3 byte transfer. waddr and wdata are valid in that same cycle and hold until the next write.
- Throughput: one byte per cycle. A write cycle may coincide with the next byte transfer.
- A frame of N words completes in 4N+2 transfers at minimum. done/error and cpu_hold change in the cycle after the checksum transfer (or after the header transfer on a bad N).
- busy=1 exactly in the cycles when state is HDR, DATA or CHK.
- The lane counter is 2 bits. The word counter is wide enough for DEPTH. waddr never exceeds DEPTH-1.

## Structure
- Package imem_pkg: state enum (IDLE, HDR, DATA, CHK, DONE, ERR), DEPTH default, ADDR_W = $clog2(DEPTH), BYTE_W=8.
- Sub-module byte_packer: byte lane register, 2-bit lane counter, XOR accumulator. Its outputs are word_valid and word. The top holds the FSM, the word counter and the write port.

## Test plan
- Nominal load: start, then 02 13 00 00 00 93 00 10 00 90 → we pulses with (0, 0x00000013) and (1, 0x00100093); done=1 and cpu_hold=0 the cycle after byte 0x90.
- Bad checksum: the same frame with final byte 0x91 → both words written, error=1, done=0, cpu_hold=1.
- Bad header: 00, and separately 65 (decimal) with DEPTH=64 → ERR after the header transfer; no we pulse.
- Gapped stream: byte_valid toggled randomly over the nominal frame → identical writes and done. No extra transfers while byte_ready=0.
- Full depth: N=0x40, 256 payload bytes → 64 writes at waddr 0..63, no wrap, done after a correct checksum.
- Reset mid-frame: rst after 6 payload bytes → all outputs return to reset values next cycle. A following start plus nominal frame loads correctly.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_pkg;

  localparam int unsigned DEPTH_DEF = 64;
  localparam int unsigned ADDR_W    = $clog2(DEPTH_DEF);
  localparam int unsigned BYTE_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CHK,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Byte-to-word packer: little-endian lane assembly plus running XOR checksum.
module byte_packer
  import imem_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  input  logic [BYTE_W-1:0]   in_data,
  output logic                word_valid,
  output logic [4*BYTE_W-1:0] word,
  output logic [BYTE_W-1:0]   acc
);

  logic [1:0]             lane_q;
  logic [BYTE_W-1:0]      lane0_q, lane1_q, lane2_q;
  logic [BYTE_W-1:0]      acc_q;

  // Lane 3 is never stored: the word is presented combinationally with the live byte.
  assign word_valid = in_valid && (lane_q == 2'd3);
  assign word       = {in_data, lane2_q, lane1_q, lane0_q};
  assign acc        = acc_q;

  // Lane counter, lane storage and checksum accumulator.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lane_q  <= '0;
      lane0_q <= '0;
      lane1_q <= '0;
      lane2_q <= '0;
      acc_q   <= '0;
    end else if (in_valid) begin
      acc_q  <= acc_q ^ in_data;
      lane_q <= lane_q + 2'd1;
      case (lane_q)
        2'd0:    lane0_q <= in_data;
        2'd1:    lane1_q <= in_data;
        2'd2:    lane2_q <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream, writes packed words into the
// instruction memory and releases the core only after a good checksum.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [WIDTH-1:0]  waddr,
  output logic [WIDTH-1:0]  wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   widx_q, widx_d;
  logic               we_q;
  logic [WIDTH-1:0]   waddr_q, wdata_q;

  logic               xfer;
  logic               pk_clr, pk_valid, pk_word_valid;
  logic [31:0]        pk_word;
  logic [7:0]         pk_acc;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pk_clr),
    .in_valid   (pk_valid),
    .in_data    (byte_data),
    .word_valid (pk_word_valid),
    .word       (pk_word),
    .acc        (pk_acc)
  );

  // State, frame length and word counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      widx_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      widx_q  <= widx_d;
    end
  end

  // Next-state logic, handshake and packer control.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    widx_d     = widx_q;
    pk_clr     = 1'b0;
    pk_valid   = 1'b0;
    byte_ready = state_q inside {HDR, DATA, CHK};
    xfer       = byte_valid && byte_ready;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) state_d = HDR;
      end
      HDR: begin
        if (xfer) begin
          if ((byte_data == '0) || (32'(byte_data) > 32'(DEPTH))) begin
            state_d = ERR;
          end else begin
            n_d     = CNT_W'(byte_data);
            widx_d  = '0;
            pk_clr  = 1'b1;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          pk_valid = 1'b1;
          if (pk_word_valid) begin
            widx_d = widx_q + CNT_W'(1);
            if (widx_q == n_q - CNT_W'(1)) state_d = CHK;
          end
        end
      end
      CHK: begin
        if (xfer) state_d = (byte_data == pk_acc) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered write port; address and data hold until the next write.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= pk_valid && pk_word_valid;
      if (pk_valid && pk_word_valid) begin
        waddr_q <= WIDTH'(widx_q);
        wdata_q <= WIDTH'(pk_word);
      end
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign busy     = byte_ready;
  assign done     = (state_q == DONE);
  assign error    = (state_q == ERR);
  assign cpu_hold = (state_q != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  imem_loader #(.WIDTH(32), .DEPTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write and transfer monitor, sampled mid-cycle.
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int unsigned n_xfer = 0;
  always @(negedge clk) begin
    if (we) begin
      wa_q.push_back(waddr);
      wd_q.push_back(wdata);
    end
    if (byte_valid && byte_ready) n_xfer++;
  end

  logic [7:0] nom [10] = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00,
                           8'h93, 8'h00, 8'h10, 8'h00, 8'h90};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned w;
    repeat (gap) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      tick();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    w = 0;
    while (!byte_ready && w < 20) begin
      tick();
      w++;
    end
    if (!byte_ready) chk("rdy_timeout", 32'(byte_ready), 32'd1);
    tick();
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  task automatic send_nom(input logic [7:0] last, input int unsigned maxgap);
    for (int i = 0; i < 10; i++)
      send_byte((i == 9) ? last : nom[i], $urandom_range(0, maxgap));
  endtask

  task automatic chk_write(input string tag, input int unsigned idx,
                           input logic [31:0] a, input logic [31:0] d);
    if (idx < wa_q.size()) begin
      chk({tag, "_addr"}, wa_q[idx], a);
      chk({tag, "_data"}, wd_q[idx], d);
    end else begin
      chk({tag, "_missing"}, 32'(wa_q.size()), 32'(idx + 1));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_we"},    32'(we),         32'd0);
    chk({tag, "_waddr"}, waddr,           32'd0);
    chk({tag, "_wdata"}, wdata,           32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
    chk({tag, "_error"}, 32'(error),      32'd0);
    chk({tag, "_hold"},  32'(cpu_hold),   32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    int unsigned x0;
    logic [7:0]  csum;
    logic [7:0]  b;
    logic [31:0] exp_w [64];

    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    tick(); tick();
    chk_reset_vals("rst");
    rst = 1'b0;
    tick();

    // Bytes offered while idle must not transfer.
    x0 = n_xfer;
    byte_valid = 1'b1; byte_data = 8'h02;
    tick(); tick(); tick();
    byte_valid = 1'b0;
    chk("idle_xfer", n_xfer - x0, 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Nominal frame with cycle-exact checks.
    base = wa_q.size();
    x0   = n_xfer;
    pulse_start();
    chk("nom_busy_hdr", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) send_byte(nom[i], 0);
    chk("nom_we0", 32'(we), 32'd1);
    chk("nom_waddr0", waddr, 32'd0);
    chk("nom_wdata0", wdata, 32'h00000013);
    send_byte(nom[5], 0);
    chk("nom_we_drop", 32'(we), 32'd0);
    chk("nom_wdata_hold", wdata, 32'h00000013);
    for (int i = 6; i < 9; i++) send_byte(nom[i], 0);
    chk("nom_we1", 32'(we), 32'd1);
    chk("nom_waddr1", waddr, 32'd1);
    chk("nom_wdata1", wdata, 32'h00100093);
    chk("nom_done_pre", 32'(done), 32'd0);
    chk("nom_hold_pre", 32'(cpu_hold), 32'd1);
    send_byte(nom[9], 0);
    chk("nom_done", 32'(done), 32'd1);
    chk("nom_hold", 32'(cpu_hold), 32'd0);
    chk("nom_error", 32'(error), 32'd0);
    chk("nom_busy", 32'(busy), 32'd0);
    chk("nom_nwr", 32'(wa_q.size() - base), 32'd2);
    chk("nom_nxfer", n_xfer - x0, 32'd10);

    // Bad checksum: words still land, frame rejected.
    base = wa_q.size();
    pulse_start();
    chk("badck_done_clr", 32'(done), 32'd0);
    send_nom(8'h91, 0);
    chk("badck_error", 32'(error), 32'd1);
    chk("badck_done", 32'(done), 32'd0);
    chk("badck_hold", 32'(cpu_hold), 32'd1);
    chk("badck_nwr", 32'(wa_q.size() - base), 32'd2);
    chk_write("badck_w0", base, 32'd0, 32'h00000013);
    chk_write("badck_w1", base + 1, 32'd1, 32'h00100093);

    // Bad headers: zero and DEPTH+1.
    base = wa_q.size();
    pulse_start();
    chk("hdr0_err_clr", 32'(error), 32'd0);
    send_byte(8'h00, 0);
    chk("hdr0_error", 32'(error), 32'd1);
    chk("hdr0_busy", 32'(busy), 32'd0);
    pulse_start();
    chk("hdr65_err_clr", 32'(error), 32'd0);
    send_byte(8'd65, 0);
    chk("hdr65_error", 32'(error), 32'd1);
    chk("hdr65_hold", 32'(cpu_hold), 32'd1);
    tick();
    chk("hdr_nwr", 32'(wa_q.size() - base), 32'd0);

    // Gapped stream.
    base = wa_q.size();
    x0   = n_xfer;
    pulse_start();
    send_nom(8'h90, 3);
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_nwr", 32'(wa_q.size() - base), 32'd2);
    chk("gap_nxfer", n_xfer - x0, 32'd10);
    chk_write("gap_w0", base, 32'd0, 32'h00000013);
    chk_write("gap_w1", base + 1, 32'd1, 32'h00100093);

    // Full depth: 64 words.
    base = wa_q.size();
    csum = 8'h00;
    pulse_start();
    send_byte(8'h40, 0);
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(i * 5 + k * 17 + 3);
        csum = csum ^ b;
        exp_w[i][k*8 +: 8] = b;
        send_byte(b, 0);
      end
    end
    send_byte(csum, 0);
    chk("full_done", 32'(done), 32'd1);
    chk("full_nwr", 32'(wa_q.size() - base), 32'd64);
    for (int i = 0; i < 64; i++)
      chk_write("full_w", base + 32'(i), 32'(i), exp_w[i]);

    // Reset in the middle of a frame, then a clean reload.
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(nom[i], 0);
    rst = 1'b1;
    tick();
    chk_reset_vals("mid_rst");
    rst = 1'b0;
    tick();
    base = wa_q.size();
    pulse_start();
    send_nom(8'h90, 0);
    chk("reload_done", 32'(done), 32'd1);
    chk("reload_nwr", 32'(wa_q.size() - base), 32'd2);
    chk_write("reload_w0", base, 32'd0, 32'h00000013);
    chk_write("reload_w1", base + 1, 32'd1, 32'h00100093);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
